// File: rtl/usb_rx_bit_decoder.sv
// usb_rx_bit_decoder: USB full-speed receive front end.
// Recovers bit timing from the synchronized D+/D- pair, NRZI-decodes each
// sampled bit, strips stuffed bits and feeds serial_in/shift_enable to the
// receive shift register. Also flags byte boundaries, EOP and stuff errors.
//
// Optional build macro USB_RX_RESYNC_EN: when defined, every D+ transition
// seen in RUN outside the sample cycle reloads the bit timer, so sampling
// re-centres on each data edge. When undefined the timer free-runs from the
// start-of-packet edge until the decoder returns to IDLE.
module usb_rx_bit_decoder #(
    parameter int CLKS_PER_BIT = 8,
    parameter int SAMPLE_PHASE = 3
) (
    input  logic clk,
    input  logic n_rst,
    input  logic d_plus,
    input  logic d_minus,
    output logic serial_in,
    output logic shift_enable,
    output logic byte_received,
    output logic eop,
    output logic stuff_err,
    output logic packet_active
);

    localparam int TIMER_W = $clog2(CLKS_PER_BIT);
    localparam logic [TIMER_W-1:0] TIMER_LAST   = TIMER_W'(CLKS_PER_BIT - 1);
    localparam logic [TIMER_W-1:0] TIMER_SAMPLE = TIMER_W'(SAMPLE_PHASE);
    localparam logic [TIMER_W-1:0] TIMER_ONE    = TIMER_W'(1);

    // Six consecutive ones force a stuffed zero on the wire.
    localparam logic [2:0] STUFF_LIMIT = 3'd6;

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] RUN      = 2'd1;
    localparam logic [1:0] EOP_WAIT = 2'd2;

    logic [1:0]         state_reg, state_next;
    logic [TIMER_W-1:0] bit_timer_reg, bit_timer_next;
    logic               prev_level_reg, prev_level_next;
    logic [2:0]         ones_count_reg, ones_count_next;
    logic [2:0]         bit_count_reg, bit_count_next;
    logic               d_plus_q_reg;

    logic serial_in_reg, serial_in_next;
    logic shift_enable_reg, shift_enable_next;
    logic byte_received_reg, byte_received_next;
    logic eop_reg, eop_next;
    logic stuff_err_reg, stuff_err_next;
    logic packet_active_reg;

    logic falling_edge;
    logic sample_event;
    logic line_se0;
    logic line_j;
    logic decoded_bit;

    assign falling_edge = d_plus_q_reg & ~d_plus;
    assign sample_event = (state_reg != IDLE) && (bit_timer_reg == TIMER_SAMPLE);
    assign line_se0     = ~d_plus & ~d_minus;
    assign line_j       = d_plus & ~d_minus;
    // NRZI: no transition means 1, a transition means 0.
    assign decoded_bit  = (d_plus == prev_level_reg);

    // Next-state logic: bit timing, NRZI decode, destuffing and pulse generation.
    always_comb begin
        state_next         = state_reg;
        bit_timer_next     = (bit_timer_reg == TIMER_LAST) ? '0 : bit_timer_reg + TIMER_ONE;
        prev_level_next    = prev_level_reg;
        ones_count_next    = ones_count_reg;
        bit_count_next     = bit_count_reg;
        serial_in_next     = serial_in_reg;
        shift_enable_next  = 1'b0;
        eop_next           = 1'b0;
        stuff_err_next     = 1'b0;
        // The 8th accepted bit wraps the count to zero as it is shifted, so the
        // pulse lands one cycle after that shift when the register is complete.
        byte_received_next = shift_enable_reg && (bit_count_reg == 3'd0);

        case (state_reg)
            IDLE: begin
                bit_timer_next = '0;
                if (falling_edge) begin
                    state_next = RUN;
                end
            end

            RUN: begin
                if (sample_event) begin
                    if (line_se0) begin
                        eop_next   = 1'b1;
                        state_next = EOP_WAIT;
                    end else begin
                        prev_level_next = d_plus;
                        if (ones_count_reg == STUFF_LIMIT) begin
                            if (!decoded_bit) begin
                                // Stuffed zero: drop it silently.
                                ones_count_next = 3'd0;
                            end else begin
                                stuff_err_next = 1'b1;
                                state_next     = EOP_WAIT;
                            end
                        end else begin
                            shift_enable_next = 1'b1;
                            serial_in_next    = decoded_bit;
                            ones_count_next   = decoded_bit ? ones_count_reg + 3'd1 : 3'd0;
                            bit_count_next    = bit_count_reg + 3'd1;
                        end
                    end
                end
`ifdef USB_RX_RESYNC_EN
                else if (d_plus != d_plus_q_reg) begin
                    // Data edge between samples: restart the bit time here.
                    bit_timer_next = '0;
                end
`endif
            end

            EOP_WAIT: begin
                // Wait for the line to return to J; edges here never restart a packet.
                if (sample_event && line_j) begin
                    state_next      = IDLE;
                    bit_timer_next  = '0;
                    bit_count_next  = 3'd0;
                    ones_count_next = 3'd0;
                    prev_level_next = 1'b1;
                end
            end

            default: begin
                state_next     = IDLE;
                bit_timer_next = '0;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_reg         <= IDLE;
            bit_timer_reg     <= '0;
            prev_level_reg    <= 1'b1;
            ones_count_reg    <= 3'd0;
            bit_count_reg     <= 3'd0;
            d_plus_q_reg      <= 1'b1;
            serial_in_reg     <= 1'b1;
            shift_enable_reg  <= 1'b0;
            byte_received_reg <= 1'b0;
            eop_reg           <= 1'b0;
            stuff_err_reg     <= 1'b0;
            packet_active_reg <= 1'b0;
        end else begin
            state_reg         <= state_next;
            bit_timer_reg     <= bit_timer_next;
            prev_level_reg    <= prev_level_next;
            ones_count_reg    <= ones_count_next;
            bit_count_reg     <= bit_count_next;
            d_plus_q_reg      <= d_plus;
            serial_in_reg     <= serial_in_next;
            shift_enable_reg  <= shift_enable_next;
            byte_received_reg <= byte_received_next;
            eop_reg           <= eop_next;
            stuff_err_reg     <= stuff_err_next;
            packet_active_reg <= (state_next != IDLE);
        end
    end

    assign serial_in     = serial_in_reg;
    assign shift_enable  = shift_enable_reg;
    assign byte_received = byte_received_reg;
    assign eop           = eop_reg;
    assign stuff_err     = stuff_err_reg;
    assign packet_active = packet_active_reg;

endmodule

// File: doc/usb_rx_bit_decoder.md
Name: usb_rx_bit_decoder

Overview:
- Front end of the USB full-speed receive path; sits directly upstream of the receive serial-to-parallel shift register.
- Recovers bit timing from the synchronized d_plus/d_minus lines and NRZI-decodes each sampled bit.
- Removes stuffed bits and drives serial_in/shift_enable into the shift register.
- Flags byte boundaries, EOP and bit-stuff errors for the RX controller.

Parameters:
- CLKS_PER_BIT, 8, clk cycles per USB bit time; must be >= 4.
- SAMPLE_PHASE, 3, bit-timer count at which the line is sampled; must be < CLKS_PER_BIT.

Ports:
- clk  input  1  system clock; all logic on posedge.
- n_rst  input  1  synchronous active-low reset.
- d_plus  input  1  D+ line, already synchronized to clk.
- d_minus  input  1  D- line, already synchronized to clk.
- serial_in  output  1  decoded data bit for the shift register; valid while shift_enable=1.
- shift_enable  output  1  one-cycle pulse per accepted (non-stuffed) bit.
- byte_received  output  1  one-cycle pulse the cycle after the 8th shift_enable of a byte.
- eop  output  1  one-cycle pulse on the first SE0 sample of a packet.
- stuff_err  output  1  one-cycle pulse on a bit-stuff violation.
- packet_active  output  1  high from start-of-packet edge until return to IDLE.

Behaviour:
- Interface decision: one clock, clk; reset n_rst is synchronous, active-low.
- Reset is sampled on posedge clk only. While n_rst=0, the following are forced:
  - Outputs: shift_enable=0, serial_in=1, byte_received=0, eop=0, stuff_err=0, packet_active=0.
  - Internal state: state=IDLE, bit timer=0, prev_level=1 (J), ones count=0, bit count=0, d_plus_q=1.
- Reset mid-packet aborts with no pulses generated.
- All outputs are registered.
- d_plus_q is a one-cycle delayed copy of d_plus. A falling edge is d_plus_q=1 and d_plus=0.
- IDLE:
  - Bit timer is held at 0.
  - On a falling edge in cycle E: go to RUN, bit timer=0 at E+1, packet_active=1 from E+1.
- RUN:
  - Bit timer increments each cycle and wraps CLKS_PER_BIT-1 -> 0.
  - A sample event occurs in the cycle the timer equals SAMPLE_PHASE. With defaults, the first sample is at E+4, then every 8 cycles.
- At each sample event, checks are applied in this priority order:
  1. SE0 (d_plus=0, d_minus=0): eop pulse next cycle, no shift_enable, go to EOP_WAIT.
  2. Otherwise decode: bit = (d_plus == prev_level); then prev_level <= d_plus.
  3. If ones count == 6 and bit=0: stuffed bit. Discard it, ones count=0, no shift_enable.
  4. If ones count == 6 and bit=1: stuff_err pulse next cycle, no shift_enable, go to EOP_WAIT.
  5. Otherwise accept: shift_enable=1 and serial_in=bit in the next cycle. Ones count = bit ? ones+1 : 0. Bit count increments mod 8.
- On the 8th accepted bit (count 7 -> 0), byte_received pulses one cycle after that shift_enable, so the shift register already holds the full byte.
- EOP_WAIT:
  - Bit timer keeps running.
  - At the first sample event with J (d_plus=1, d_minus=0): go to IDLE, packet_active=0 next cycle.
  - Entering IDLE resets bit count, ones count and prev_level=1.
  - Further SE0 samples do not re-pulse eop.
- Partial byte at EOP: no byte_received; the bit count is discarded.
- Falling edges in EOP_WAIT are ignored; edges only start a packet from IDLE.
- Pulse timing: at most one shift_enable per bit time; shift_enable and stuff_err are never high together.

Optional Feature:
- Macro: USB_RX_RESYNC_EN.
- Defined: in RUN, any d_plus transition (d_plus != d_plus_q) in a non-sample cycle reloads the bit timer to 0 in the next cycle. Sampling re-centres on every data edge, tolerating +/-1 clk drift per bit.
- Undefined: the bit timer free-runs from the start edge until IDLE; no resynchronization logic is present.

Test Plan:
- Reset: toggle d_plus every cycle with n_rst=0 for 3 cycles -> all outputs at reset values; no pulses; packet_active=0 for one cycle after release with the line at J.
- Sync byte: drive KJKJKJKK at 8 clk/bit from J idle -> 8 shift_enable pulses 8 cycles apart, first at E+5; serial_in = 0,0,0,0,0,0,0,1; byte_received once; an LSB-first shift register holds 0x80.
- Stuffing: sync, then 0xFF with the stuffed K after six 1s -> 9 line bits give exactly 8 shift_enable pulses, all serial_in=1; stuffed bit dropped; stuff_err=0; byte_received once.
- Stuff error: sync, then seven line bits with no transition -> 6 accepted 1s, stuff_err pulse on the 7th sample, no 7th shift_enable, state EOP_WAIT.
- EOP: sync + 0xA5, then SE0 for 2 bits, then J -> eop pulses exactly once; no extra shift_enable; packet_active drops one cycle after the J sample; a following falling edge starts a new packet.
- Drift (macro defined): 24 bits at 9 clk/bit -> every bit decoded correctly. Macro undefined: same stimulus is permitted to mis-sample; the check is no lockup, with return to IDLE after the trailing SE0+J.
